// File: rtl/barcode_rx_param.sv
// Parametrised self-clocked barcode receiver: measures the start-cell low time and
// samples each following cell that many clocks after its falling edge, MSB first.
module barcode_rx_param #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 22,
  parameter int PARITY_EN = 0,
  parameter int TO_SHIFT  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              BC,
  input  logic              clr_ID_vld,
  output logic              ID_vld,
  output logic [DATA_W-1:0] ID,
  output logic              frame_err,
  output logic              ovr,
  output logic [2:0]        state_dbg
);

  localparam int SH_W  = DATA_W + PARITY_EN;
  localparam int BIT_W = $clog2(SH_W + 1);
  localparam int TO_W  = CNT_W + TO_SHIFT;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_FALL = 3'd2,
    SAMPLE    = 3'd3,
    CHECK     = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic             bc_meta, bc_sync, bc_prev;
  logic             fall;
  logic [CNT_W-1:0] cnt, ref_low;
  logic [TO_W:0]    to_cnt;
  logic [TO_W-1:0]  to_limit;
  logic [BIT_W-1:0] bitcnt;
  logic [SH_W-1:0]  shreg;
  logic             cnt_max, to_expired, par_ok, last_bit;

  // Control strobes from the output decoder
  logic cnt_load, cnt_inc, ref_load, samp, to_clr, to_inc, err_evt, good;

  assign fall       = bc_prev & ~bc_sync;
  assign cnt_max    = (cnt == {CNT_W{1'b1}});
  assign to_limit   = TO_W'(ref_low) << TO_SHIFT;
  assign to_expired = (to_cnt > {1'b0, to_limit});
  assign last_bit   = (bitcnt == BIT_W'(SH_W - 1));
  // Even parity: data plus parity bit must XOR to zero
  assign par_ok     = (PARITY_EN == 0) || (^shreg == 1'b0);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (fall) state_nxt = START;
      START:     if (bc_sync) state_nxt = WAIT_FALL;
                 else if (cnt_max) state_nxt = IDLE;
      WAIT_FALL: if (fall) state_nxt = SAMPLE;
                 else if (to_expired) state_nxt = IDLE;
      SAMPLE:    if (cnt == ref_low) state_nxt = last_bit ? CHECK : WAIT_FALL;
      CHECK:     state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    ref_load = 1'b0;
    samp     = 1'b0;
    to_inc   = 1'b0;
    err_evt  = 1'b0;
    good     = 1'b0;
    case (state)
      IDLE:      cnt_load = fall;
      START: begin
        ref_load = bc_sync;
        cnt_inc  = ~bc_sync & ~cnt_max;
        err_evt  = ~bc_sync & cnt_max;
      end
      WAIT_FALL: begin
        cnt_load = fall;
        to_inc   = ~fall;
        err_evt  = ~fall & to_expired;
      end
      SAMPLE: begin
        cnt_inc = 1'b1;
        samp    = (cnt == ref_low);
      end
      CHECK: begin
        good    = par_ok;
        err_evt = ~par_ok;
      end
      default: ;
    endcase
  end

  assign to_clr = ref_load | samp;

  always_ff @(posedge clk) begin
    if (rst) begin
      bc_meta   <= 1'b1;
      bc_sync   <= 1'b1;
      bc_prev   <= 1'b1;
      cnt       <= '0;
      ref_low   <= '0;
      to_cnt    <= '0;
      bitcnt    <= '0;
      shreg     <= '0;
      ID        <= '0;
      ID_vld    <= 1'b0;
      frame_err <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      bc_meta <= BC;
      bc_sync <= bc_meta;
      bc_prev <= bc_sync;

      if (cnt_load)     cnt <= CNT_W'(1);
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);

      if (to_clr)      to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + 1'b1;

      if (ref_load) begin
        ref_low <= cnt;
        bitcnt  <= '0;
      end
      if (samp) begin
        shreg  <= {shreg[SH_W-2:0], bc_sync};
        bitcnt <= bitcnt + 1'b1;
      end

      // A good frame beats a same-cycle acknowledge so the new ID is never lost
      if (good) begin
        ID     <= shreg[SH_W-1 -: DATA_W];
        ID_vld <= 1'b1;
      end else if (clr_ID_vld) begin
        ID_vld <= 1'b0;
      end

      if (clr_ID_vld)        ovr <= 1'b0;
      else if (good && ID_vld) ovr <= 1'b1;

      if (err_evt)         frame_err <= 1'b1;
      else if (clr_ID_vld) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_barcode_rx_param.sv
// Bench for barcode_rx_param: drives bit cells onto BC and compares the outputs with a
// frame-level reference model (plain/parity instances side by side).
module tb_barcode_rx_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bc_line = 1'b1;
  logic       clr = 1'b0;
  logic       sel_p = 1'b0;
  logic       bc_a, bc_p, clr_a, clr_p;
  logic       vld_a, vld_p, err_a, err_p, ovr_a, ovr_p;
  logic [7:0] id_a, id_p;
  logic [2:0] st_a, st_p;
  logic       act_vld, act_err, act_ovr;
  logic [7:0] act_id;

  int checks = 0;
  int errors = 0;

  logic       exp_vld, exp_err, exp_ovr;
  logic [7:0] exp_id;
  logic [7:0] exp_q[$];
  logic       probe0, probe1;

  always #5 clk = ~clk;

  assign bc_a  = sel_p ? 1'b1 : bc_line;
  assign bc_p  = sel_p ? bc_line : 1'b1;
  assign clr_a = sel_p ? 1'b0 : clr;
  assign clr_p = sel_p ? clr : 1'b0;
  assign act_vld = sel_p ? vld_p : vld_a;
  assign act_err = sel_p ? err_p : err_a;
  assign act_ovr = sel_p ? ovr_p : ovr_a;
  assign act_id  = sel_p ? id_p  : id_a;

  barcode_rx_param #(.DATA_W(8), .CNT_W(22), .PARITY_EN(0), .TO_SHIFT(3)) dut (
    .clk(clk), .rst(rst), .BC(bc_a), .clr_ID_vld(clr_a), .ID_vld(vld_a), .ID(id_a),
    .frame_err(err_a), .ovr(ovr_a), .state_dbg(st_a));

  barcode_rx_param #(.DATA_W(8), .CNT_W(22), .PARITY_EN(1), .TO_SHIFT(3)) dut_p (
    .clk(clk), .rst(rst), .BC(bc_p), .clr_ID_vld(clr_p), .ID_vld(vld_p), .ID(id_p),
    .frame_err(err_p), .ovr(ovr_p), .state_dbg(st_p));

  // ---------------- reference model ----------------
  task automatic model_reset();
    exp_vld = 1'b0; exp_err = 1'b0; exp_ovr = 1'b0; exp_id = 8'h00;
    exp_q.delete();
  endtask

  task automatic model_frame(input logic [7:0] data, input logic ok, input logic clr_same);
    if (ok) begin
      exp_ovr = clr_same ? 1'b0 : (exp_ovr | exp_vld);
      exp_err = clr_same ? 1'b0 : exp_err;
      exp_vld = 1'b1;
      exp_q.push_back(data);
      exp_id = exp_q[$];
    end else begin
      exp_err = 1'b1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_cell(input int low, input int period, input int clr_at,
                           input int rst_at, input int probe_at);
    for (int k = 0; k < period; k++) begin
      @(negedge clk);
      bc_line = (k < low) ? 1'b0 : 1'b1;
      clr = (k == clr_at);
      rst = (k == rst_at);
      if (k == probe_at)     probe0 = act_vld;
      if (k == probe_at + 1) probe1 = act_vld;
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bc_line = 1'b1; clr = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] data, input logic par_bad, input int r,
                       input int one_lo, input int zero_lo, input int period,
                       input logic clr_chk, input logic probe);
    logic [8:0] bits;
    int nbits, cat;
    bits  = sel_p ? {data, (^data) ^ par_bad} : {1'b0, data};
    nbits = sel_p ? 9 : 8;
    send_cell(r, period, -1, -1, -1);
    for (int i = 0; i < nbits; i++) begin
      cat = (i == nbits - 1) ? r + 3 : -1;
      send_cell(bits[nbits-1-i] ? one_lo : zero_lo, period,
                clr_chk ? cat : -1, -1, probe ? cat : -1);
    end
    idle(6);
    model_frame(data, !(sel_p && par_bad), clr_chk);
  endtask

  task automatic clr_pulse();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    exp_vld = 1'b0; exp_err = 1'b0; exp_ovr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; bc_line = 1'b1; clr = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    model_reset();
    idle(3);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    sel_p = 1'b0;
    do_reset();
    checks++;
    if ({vld_a, id_a, err_a, ovr_a} !== 11'd0 || {vld_p, id_p, err_p, ovr_p} !== 11'd0) begin
      errors++;
      $display("FAIL reset: got a=%b/%h/%b/%b p=%b/%h/%b/%b expected all zero",
               vld_a, id_a, err_a, ovr_a, vld_p, id_p, err_p, ovr_p);
    end
  endtask

  task automatic test_basic();
    probe0 = 1'bx; probe1 = 1'bx;
    frame(8'hAE, 1'b0, 512, 256, 768, 1024, 1'b0, 1'b1);
    checks++;
    if ({probe0, probe1} !== 2'b01) begin
      errors++;
      $display("FAIL vld_latency: got check/after=%b%b expected 01", probe0, probe1);
    end
    checks++;
    if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
      errors++;
      $display("FAIL basic_0xAE: got vld=%b id=%h err=%b ovr=%b expected vld=%b id=%h err=%b ovr=%b",
               act_vld, act_id, act_err, act_ovr, exp_vld, exp_id, exp_err, exp_ovr);
    end
  endtask

  task automatic test_clr_second();
    clr_pulse();
    idle(1);
    checks++;
    if (act_vld !== 1'b0 || act_id !== exp_id) begin
      errors++;
      $display("FAIL clr_drop: got vld=%b id=%h expected vld=0 id=%h", act_vld, act_id, exp_id);
    end
    frame(8'hA8, 1'b0, 256, 128, 384, 513, 1'b0, 1'b0);
    checks++;
    if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
      errors++;
      $display("FAIL period513_0xA8: got vld=%b id=%h err=%b ovr=%b expected vld=%b id=%h err=%b ovr=%b",
               act_vld, act_id, act_err, act_ovr, exp_vld, exp_id, exp_err, exp_ovr);
    end
  endtask

  task automatic test_parity();
    sel_p = 1'b1;
    do_reset();
    frame(8'h3C, 1'b0, 128, 64, 192, 256, 1'b0, 1'b0);
    checks++;
    if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
      errors++;
      $display("FAIL parity_good: got vld=%b id=%h err=%b ovr=%b expected vld=%b id=%h err=%b ovr=%b",
               act_vld, act_id, act_err, act_ovr, exp_vld, exp_id, exp_err, exp_ovr);
    end
    clr_pulse();
    frame(8'hA8, 1'b1, 128, 64, 192, 256, 1'b0, 1'b0);
    checks++;
    if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
      errors++;
      $display("FAIL parity_bad: got vld=%b id=%h err=%b ovr=%b expected vld=%b id=%h err=%b ovr=%b",
               act_vld, act_id, act_err, act_ovr, exp_vld, exp_id, exp_err, exp_ovr);
    end
    sel_p = 1'b0;
  endtask

  task automatic test_timeout();
    int cyc, exp_cyc;
    logic [7:0] d;
    d = 8'hB0;
    do_reset();
    send_cell(512, 1024, -1, -1, -1);
    for (int i = 0; i < 3; i++) send_cell(d[7-i] ? 256 : 768, 1024, -1, -1, -1);
    // Timeout window counts from the last sample point (ref_low after its fall)
    exp_cyc = (512 << 3) + 512 + 6 - 1024;
    cyc = 0;
    for (int n = 1; n <= 6000 && cyc == 0; n++) begin
      @(negedge clk);
      if (act_err === 1'b1) cyc = n;
    end
    checks++;
    if (cyc < exp_cyc - 32 || cyc > exp_cyc + 32) begin
      errors++;
      $display("FAIL timeout_time: got %0d clks expected about %0d (0 = never)", cyc, exp_cyc);
    end
    exp_err = 1'b1;
    checks++;
    if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
      errors++;
      $display("FAIL timeout_flags: got vld=%b id=%h err=%b ovr=%b expected vld=%b id=%h err=%b ovr=%b",
               act_vld, act_id, act_err, act_ovr, exp_vld, exp_id, exp_err, exp_ovr);
    end
    clr_pulse();
    frame(8'h3C, 1'b0, 128, 64, 192, 256, 1'b0, 1'b0);
    checks++;
    if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
      errors++;
      $display("FAIL after_timeout_0x3C: got vld=%b id=%h err=%b ovr=%b expected vld=%b id=%h err=%b ovr=%b",
               act_vld, act_id, act_err, act_ovr, exp_vld, exp_id, exp_err, exp_ovr);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hA5;
    frame(8'h99, 1'b0, 32, 16, 48, 64, 1'b0, 1'b0);
    send_cell(128, 256, -1, -1, -1);
    for (int i = 0; i < 4; i++) send_cell(d[7-i] ? 64 : 192, 256, -1, -1, -1);
    send_cell(d[3] ? 64 : 192, 256, -1, 50, -1);
    model_reset();
    checks++;
    if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
      errors++;
      $display("FAIL mid_frame_reset: got vld=%b id=%h err=%b ovr=%b expected all zero",
               act_vld, act_id, act_err, act_ovr);
    end
    for (int i = 5; i < 8; i++) send_cell(d[7-i] ? 64 : 192, 256, -1, -1, -1);
    idle(12 * 256);
    exp_err = 1'b1;
    checks++;
    if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
      errors++;
      $display("FAIL remnant_edges: got vld=%b id=%h err=%b ovr=%b expected vld=%b id=%h err=%b ovr=%b",
               act_vld, act_id, act_err, act_ovr, exp_vld, exp_id, exp_err, exp_ovr);
    end
    clr_pulse();
    frame(8'h55, 1'b0, 128, 64, 192, 256, 1'b0, 1'b0);
    checks++;
    if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
      errors++;
      $display("FAIL after_reset_0x55: got vld=%b id=%h err=%b ovr=%b expected vld=%b id=%h err=%b ovr=%b",
               act_vld, act_id, act_err, act_ovr, exp_vld, exp_id, exp_err, exp_ovr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    frame(8'h11, 1'b0, 64, 32, 96, 128, 1'b0, 1'b0);
    frame(8'h22, 1'b0, 64, 32, 96, 128, 1'b0, 1'b0);
    checks++;
    if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
      errors++;
      $display("FAIL overrun: got vld=%b id=%h err=%b ovr=%b expected vld=%b id=%h err=%b ovr=%b",
               act_vld, act_id, act_err, act_ovr, exp_vld, exp_id, exp_err, exp_ovr);
    end
    clr_pulse();
    frame(8'h11, 1'b0, 64, 32, 96, 128, 1'b0, 1'b0);
    frame(8'h22, 1'b0, 64, 32, 96, 128, 1'b1, 1'b0);
    checks++;
    if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
      errors++;
      $display("FAIL clr_on_check: got vld=%b id=%h err=%b ovr=%b expected vld=%b id=%h err=%b ovr=%b",
               act_vld, act_id, act_err, act_ovr, exp_vld, exp_id, exp_err, exp_ovr);
    end
  endtask

  task automatic test_min_ref();
    logic [7:0] d;
    do_reset();
    for (int n = 0; n < 3; n++) begin
      d = 8'($urandom_range(0, 255));
      frame(d, 1'b0, 1, 1, 2, 5, 1'b0, 1'b0);
      checks++;
      if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
        errors++;
        $display("FAIL ref_low_1 #%0d: got vld=%b id=%h err=%b ovr=%b expected vld=%b id=%h err=%b ovr=%b",
                 n, act_vld, act_id, act_err, act_ovr, exp_vld, exp_id, exp_err, exp_ovr);
      end
    end
  endtask

  task automatic test_random();
    int r, one_lo, zero_lo, period;
    logic [7:0] d;
    logic bad;
    for (int n = 0; n < 20; n++) begin
      if (n == 0 || n == 12) begin
        sel_p = (n == 12);
        do_reset();
      end
      r       = $urandom_range(2, 40);
      one_lo  = $urandom_range(1, r);
      zero_lo = $urandom_range(r + 1, 2 * r);
      period  = zero_lo + $urandom_range(2, 10);
      d       = 8'($urandom_range(0, 255));
      bad     = sel_p && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) clr_pulse();
      frame(d, bad, r, one_lo, zero_lo, period, 1'b0, 1'b0);
      checks++;
      if ({act_vld, act_id, act_err, act_ovr} !== {exp_vld, exp_id, exp_err, exp_ovr}) begin
        errors++;
        $display("FAIL random #%0d p=%0d r=%0d: got vld=%b id=%h err=%b ovr=%b expected vld=%b id=%h err=%b ovr=%b",
                 n, sel_p, r, act_vld, act_id, act_err, act_ovr, exp_vld, exp_id, exp_err, exp_ovr);
      end
    end
    sel_p = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_clr_second();
    test_parity();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    test_min_ref();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule
